paillier_result_collector: RTL and testbench
============================================

Name: paillier_result_collector

Overview:
- Sits downstream of the per-block result FIFOs (depth 2N, width K) and upstream of the AXI-FULL write path.
- Round-robin scans all BLOCK_COUNT FIFOs and selects one holding a complete result group of N words.
- Drains that group as one tagged K-bit valid/ready stream with a last flag.
- Counts groups against a programmed job total and pulses done when the job completes.

Parameters:
BLOCK_COUNT, 25, number of paillier cores / result FIFOs
K, 128, result word width in bits
N, 32, words per result group; one AXI write burst
CW, $clog2(N)+1, width of each FIFO occupancy count

Ports:
clk  in  1  single clock for all logic
rst  in  1  asynchronous reset, active-high
job_start  in  1  one-cycle pulse; loads job_groups; ignored unless idle
job_groups  in  32  number of N-word groups to collect in this job
job_busy  out  1  high from accepted job_start until done
job_done  out  1  one-cycle pulse when last group fully accepted
rd_rdy  out  BLOCK_COUNT  per-FIFO pop strobe; at most one bit set
rd_dout  in  BLOCK_COUNT*K  show-ahead head word of each FIFO; slice i = FIFO i
rd_cnt  in  BLOCK_COUNT*CW  occupancy of each FIFO; slice i = FIFO i
m_data  out  K  result word
m_block  out  $clog2(BLOCK_COUNT)  index of source FIFO
m_last  out  1  marks word N-1 of a group
m_valid  out  1  output word valid
m_ready  in  1  downstream accept

Behaviour:
- Reset: all state cleared asynchronously.
  - Outputs at reset: rd_rdy=0, m_valid=0, m_last=0, m_data=0, m_block=0, job_busy=0, job_done=0.
  - State at reset: rr_ptr=BLOCK_COUNT-1, state=IDLE.
- FIFOs are show-ahead: rd_dout slice i is valid whenever rd_cnt slice i is nonzero. Asserting rd_rdy[i] pops one word in that cycle.
- States: IDLE, SCAN, XFER, DONE.
- IDLE:
  - job_start with job_groups!=0: load groups_left=job_groups, set job_busy, go to SCAN.
  - job_start with job_groups==0: go directly to DONE.
- SCAN:
  - Candidate i is eligible when rd_cnt[i] >= N.
  - Pick the first eligible index searching rr_ptr+1, rr_ptr+2, … with wrap modulo BLOCK_COUNT.
  - Selection is combinational and takes one cycle. Register sel, load word_cnt=0, go to XFER.
  - No eligible FIFO: stay in SCAN indefinitely.
- XFER:
  - pop = (word_cnt < N) && (!m_valid || m_ready). This is a combinational path from m_ready to rd_rdy by design.
  - rd_rdy[sel] = pop.
  - On pop: m_data <= rd_dout[sel], m_block <= sel, m_valid <= 1, m_last <= (word_cnt==N-1), word_cnt++.
  - m_ready && m_valid && !pop: m_valid <= 0.
  - Exit when the output word with m_last=1 is accepted (m_valid && m_ready && m_last):
    - rr_ptr <= sel, groups_left--.
    - If groups_left was 1, go to DONE; else go to SCAN.
    - The cycle leaving XFER clears m_valid and m_last.
- DONE: job_done=1 for exactly one cycle, job_busy cleared, return to IDLE.
- Stream rules:
  - m_data, m_block and m_last stay stable while m_valid && !m_ready.
  - Zero bubbles within a group when m_ready is held high; 1 word/cycle.
  - Latency from entering SCAN to first m_valid is 2 cycles.
- Concurrency and boundaries:
  - A FIFO filling during XFER of another FIFO is not seen until the next SCAN.
  - Simultaneous eligibility is resolved only by round-robin order; the last-served FIFO has lowest priority next.
  - rd_cnt is compared unsigned; its width bounds eligibility exactly at N.
  - job_start while job_busy is ignored; groups_left is not disturbed.
  - Reset mid-group discards the partial group. The FIFO contents already popped are lost; recovery is the job owner's responsibility.

Decomposition:
- Package paillier_collect_pkg:
  - state enum (IDLE, SCAN, XFER, DONE)
  - localparams for index width and CW
  - function rr_pick(eligible vector, ptr) returning index and found flag.
- One natural sub-module: rr_arbiter_comb (rotate, priority-encode, un-rotate), parameterised by BLOCK_COUNT.

Test Plan:
- BLOCK_COUNT=4, N=4, job_groups=1; FIFO2 filled with 4 words 0xA0..0xA3, m_ready=1.
  - m_valid exactly 2 cycles after SCAN entry; 4 consecutive words A0..A3 with m_block=2; m_last on A3; job_done pulses one cycle after the A3 handshake.
- All four FIFOs full, job_groups=4.
  - Service order 0,1,2,3; then refill all and start job_groups=2: order 0,1 (round-robin resumes after the last served).
- m_ready toggled 1,0,0,1 during a group.
  - No duplicate or dropped words; data stable while stalled; rd_rdy never asserted while m_valid && !m_ready.
- FIFO1 holds N-1 words, FIFO3 holds N.
  - FIFO3 served; FIFO1 is served only after its Nth word arrives.
  - job_start with job_groups=0: job_done pulses with no rd_rdy activity.
- rst asserted mid-group after 2 words.
  - All outputs return to reset values immediately (asynchronous).
  - job_busy=0; a new job_start after deassertion is accepted normally.

Source files
------------

// File: rtl/paillier_collect_pkg.sv
// Shared types and helpers for the Paillier result collector.
package paillier_collect_pkg;

    // Upper bound on FIFOs the round-robin helper can handle
    localparam int unsigned MAX_BLOCKS = 64;
    localparam int unsigned IDX_W_MAX  = $clog2(MAX_BLOCKS);

    // Default build: 25 cores, 32-word groups
    localparam int unsigned BLOCK_COUNT_DEF = 25;
    localparam int unsigned N_DEF           = 32;
    localparam int unsigned IDX_W_DEF       = $clog2(BLOCK_COUNT_DEF);
    localparam int unsigned CW_DEF          = $clog2(N_DEF) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic                 found;
        logic [IDX_W_MAX-1:0] idx;
    } rr_pick_t;

    // First eligible index after ptr, wrapping modulo count.
    // Rotate so bit 0 is ptr+1, take the lowest set bit, then un-rotate.
    function automatic rr_pick_t rr_pick(input logic [MAX_BLOCKS-1:0] elig,
                                         input logic [IDX_W_MAX-1:0]  ptr,
                                         input int unsigned           count);
        logic [MAX_BLOCKS-1:0] rot;
        int unsigned           off;
        rr_pick_t              res;
        rot = '0;
        off = 0;
        res = '0;
        for (int unsigned k = 0; k < MAX_BLOCKS; k++) begin
            if (k < count) begin
                rot[k] = elig[IDX_W_MAX'((32'(ptr) + k + 1) % count)];
            end
        end
        for (int unsigned k = 0; k < MAX_BLOCKS; k++) begin
            if (rot[k] && !res.found) begin
                res.found = 1'b1;
                off       = k;
            end
        end
        if (res.found) begin
            res.idx = IDX_W_MAX'((32'(ptr) + off + 1) % count);
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter_comb.sv
// Combinational round-robin picker over BLOCK_COUNT request lines.
module rr_arbiter_comb
    import paillier_collect_pkg::*;
#(
    parameter int unsigned BLOCK_COUNT = 25,
    localparam int unsigned IDX_W = (BLOCK_COUNT > 1) ? $clog2(BLOCK_COUNT) : 1
) (
    input  logic [BLOCK_COUNT-1:0] eligible,
    input  logic [IDX_W-1:0]       ptr,
    output logic                   found_c,
    output logic [IDX_W-1:0]       idx_c
);

    rr_pick_t pick_c;

    // Search starts just after the last-served index
    always_comb begin
        pick_c  = rr_pick(MAX_BLOCKS'(eligible), IDX_W_MAX'(ptr), BLOCK_COUNT);
        found_c = pick_c.found;
        idx_c   = IDX_W'(pick_c.idx);
    end

endmodule

// File: rtl/paillier_result_collector.sv
// Round-robin collector: drains N-word result groups from per-core FIFOs
// into one tagged valid/ready stream and counts groups against a job total.
module paillier_result_collector
    import paillier_collect_pkg::*;
#(
    parameter int unsigned BLOCK_COUNT = 25,
    parameter int unsigned K           = 128,
    parameter int unsigned N           = 32,
    parameter int unsigned CW          = $clog2(N) + 1,
    localparam int unsigned IDX_W = (BLOCK_COUNT > 1) ? $clog2(BLOCK_COUNT) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      job_start,
    input  logic [31:0]               job_groups,
    output logic                      job_busy,
    output logic                      job_done,
    output logic [BLOCK_COUNT-1:0]    rd_rdy,
    input  logic [BLOCK_COUNT*K-1:0]  rd_dout,
    input  logic [BLOCK_COUNT*CW-1:0] rd_cnt,
    output logic [K-1:0]              m_data,
    output logic [IDX_W-1:0]          m_block,
    output logic                      m_last,
    output logic                      m_valid,
    input  logic                      m_ready
);

    localparam int unsigned WC_W = $clog2(N + 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [WC_W-1:0]    word_cnt_q, word_cnt_d;
    logic [31:0]        groups_left_q, groups_left_d;
    logic               job_busy_q, job_busy_d;
    logic               job_done_q, job_done_d;
    logic [K-1:0]       m_data_q, m_data_d;
    logic [IDX_W-1:0]   m_block_q, m_block_d;
    logic               m_last_q, m_last_d;
    logic               m_valid_q, m_valid_d;

    logic [BLOCK_COUNT-1:0] elig_c;
    logic                   pick_found_c;
    logic [IDX_W-1:0]       pick_idx_c;
    logic                   pop_c;
    logic [K-1:0]           head_c;

    // A FIFO is a candidate once it holds a full group
    always_comb begin
        elig_c = '0;
        for (int unsigned i = 0; i < BLOCK_COUNT; i++) begin
            elig_c[i] = rd_cnt[i*CW +: CW] >= CW'(N);
        end
    end

    rr_arbiter_comb #(
        .BLOCK_COUNT (BLOCK_COUNT)
    ) u_arb (
        .eligible (elig_c),
        .ptr      (rr_ptr_q),
        .found_c  (pick_found_c),
        .idx_c    (pick_idx_c)
    );

    // Pop when words remain and the output register is free or draining;
    // m_ready feeds rd_rdy combinationally so the group streams at full rate
    always_comb begin
        pop_c  = (state_q == XFER) && (word_cnt_q < WC_W'(N)) && (!m_valid_q || m_ready);
        rd_rdy = '0;
        if (pop_c) begin
            rd_rdy[sel_q] = 1'b1;
        end
        head_c = rd_dout[32'(sel_q)*K +: K];
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        sel_d         = sel_q;
        word_cnt_d    = word_cnt_q;
        groups_left_d = groups_left_q;
        job_busy_d    = job_busy_q;
        job_done_d    = 1'b0;
        m_data_d      = m_data_q;
        m_block_d     = m_block_q;
        m_last_d      = m_last_q;
        m_valid_d     = m_valid_q;

        unique case (state_q)
            IDLE: begin
                if (job_start) begin
                    if (job_groups != 32'd0) begin
                        groups_left_d = job_groups;
                        job_busy_d    = 1'b1;
                        state_d       = SCAN;
                    end else begin
                        job_done_d = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            SCAN: begin
                if (pick_found_c) begin
                    sel_d      = pick_idx_c;
                    word_cnt_d = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                if (pop_c) begin
                    m_data_d   = head_c;
                    m_block_d  = sel_q;
                    m_valid_d  = 1'b1;
                    m_last_d   = (word_cnt_q == WC_W'(N - 1));
                    word_cnt_d = word_cnt_q + WC_W'(1);
                end else if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    if (m_last_q) begin
                        m_last_d      = 1'b0;
                        rr_ptr_d      = sel_q;
                        groups_left_d = groups_left_q - 32'd1;
                        if (groups_left_q == 32'd1) begin
                            job_done_d = 1'b1;
                            job_busy_d = 1'b0;
                            state_d    = DONE;
                        end else begin
                            state_d = SCAN;
                        end
                    end
                end
            end
            DONE: begin
                job_busy_d = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= IDX_W'(BLOCK_COUNT - 1);
            sel_q         <= '0;
            word_cnt_q    <= '0;
            groups_left_q <= '0;
            job_busy_q    <= 1'b0;
            job_done_q    <= 1'b0;
            m_data_q      <= '0;
            m_block_q     <= '0;
            m_last_q      <= 1'b0;
            m_valid_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            sel_q         <= sel_d;
            word_cnt_q    <= word_cnt_d;
            groups_left_q <= groups_left_d;
            job_busy_q    <= job_busy_d;
            job_done_q    <= job_done_d;
            m_data_q      <= m_data_d;
            m_block_q     <= m_block_d;
            m_last_q      <= m_last_d;
            m_valid_q     <= m_valid_d;
        end
    end

    assign job_busy = job_busy_q;
    assign job_done = job_done_q;
    assign m_data   = m_data_q;
    assign m_block  = m_block_q;
    assign m_last   = m_last_q;
    assign m_valid  = m_valid_q;

endmodule

// File: tb/tb_paillier_result_collector.sv
// Bench for the Paillier result collector: queue-based FIFO models feed the
// DUT, and a group-level round-robin model predicts the output stream.
module tb_paillier_result_collector;

    localparam int unsigned BC = 4;
    localparam int unsigned K  = 32;
    localparam int unsigned N  = 4;
    localparam int unsigned CW = 3;
    localparam int unsigned IW = 2;

    typedef struct packed {
        logic [K-1:0]  data;
        logic [IW-1:0] blk;
        logic          last;
    } word_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              job_start;
    logic [31:0]       job_groups;
    logic              job_busy;
    logic              job_done;
    logic [BC-1:0]     rd_rdy;
    logic [BC*K-1:0]   rd_dout;
    logic [BC*CW-1:0]  rd_cnt;
    logic [K-1:0]      m_data;
    logic [IW-1:0]     m_block;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;

    always #5 clk = ~clk;

    paillier_result_collector #(
        .BLOCK_COUNT (BC),
        .K           (K),
        .N           (N),
        .CW          (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .job_start  (job_start),
        .job_groups (job_groups),
        .job_busy   (job_busy),
        .job_done   (job_done),
        .rd_rdy     (rd_rdy),
        .rd_dout    (rd_dout),
        .rd_cnt     (rd_cnt),
        .m_data     (m_data),
        .m_block    (m_block),
        .m_last     (m_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    int checks   = 0;
    int failures = 0;

    logic [K-1:0] fq[BC][$];
    word_t        acc_q[$];
    int           acc_cyc[$];
    word_t        exp_q[$];
    int cyc = 0;
    int start_cyc = 0;
    int first_valid_cyc = -1;
    int done_cnt = 0;
    int done_cyc = 0;
    int pop_cnt = 0;
    int viol_stall = 0;
    int viol_stable = 0;
    int viol_onehot = 0;
    int rdy_mode = 0;
    int rdy_idx = 0;
    int model_ptr = BC - 1;
    logic  prev_stall = 1'b0;
    word_t prev_w = '0;

    task automatic refresh();
        for (int i = 0; i < BC; i++) begin
            rd_dout[i*K +: K]   = (fq[i].size() > 0) ? fq[i][0] : '0;
            rd_cnt[i*CW +: CW]  = CW'(fq[i].size());
        end
    endtask

    // One clock: drive m_ready, sample the pre-edge handshake/pops, clock,
    // then retire popped words from the FIFO models at the falling edge
    task automatic step();
        word_t         w;
        logic [BC-1:0] pops;
        logic          hs;
        case (rdy_mode)
            1:       begin m_ready = ((rdy_idx % 4) == 0) || ((rdy_idx % 4) == 3); rdy_idx++; end
            2:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b1;
        endcase
        #1;
        cyc++;
        pops = rd_rdy;
        hs   = m_valid && m_ready;
        w    = {m_data, m_block, m_last};
        if ($countones(pops) > 1) viol_onehot++;
        if (m_valid && !m_ready && pops != '0) viol_stall++;
        if (prev_stall && (w !== prev_w || !m_valid)) viol_stable++;
        prev_stall = m_valid && !m_ready;
        prev_w     = w;
        if (hs) begin
            acc_q.push_back(w);
            acc_cyc.push_back(cyc);
        end
        pop_cnt += $countones(pops);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < BC; i++) begin
            if (pops[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        end
        refresh();
        if (job_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        job_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_ptr  = BC - 1;
        prev_stall = 1'b0;
    endtask

    task automatic start_job(input int g);
        acc_q.delete();
        acc_cyc.delete();
        done_cnt = 0;
        first_valid_cyc = -1;
        job_groups = 32'(g);
        job_start  = 1'b1;
        step();
        start_cyc = cyc;
        job_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        timed_out = (done_cnt == 0);
        repeat (2) step();
    endtask

    task automatic fill_rand(input int f, input int cnt);
        for (int i = 0; i < cnt; i++) fq[f].push_back(K'($urandom));
    endtask

    // Group-level model: each group goes to the first FIFO after the last
    // served one (wrapping) that holds at least N words
    task automatic build_expected(input int groups);
        int sz[BC];
        int offs[BC];
        int ptr;
        int pick;
        ptr = model_ptr;
        exp_q.delete();
        for (int i = 0; i < BC; i++) begin
            sz[i]   = fq[i].size();
            offs[i] = 0;
        end
        for (int g = 0; g < groups; g++) begin
            pick = -1;
            for (int k = 1; k <= BC; k++) begin
                if (pick < 0 && sz[(ptr + k) % BC] >= N) pick = (ptr + k) % BC;
            end
            if (pick >= 0) begin
                for (int w = 0; w < N; w++) begin
                    exp_q.push_back({fq[pick][offs[pick] + w], IW'(pick), (w == N - 1)});
                end
                offs[pick] += N;
                sz[pick]   -= N;
                ptr = pick;
            end
        end
        model_ptr = ptr;
    endtask

    function automatic int first_diff();
        int n;
        n = (acc_q.size() < exp_q.size()) ? acc_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (acc_q[i] !== exp_q[i]) return i;
        end
        if (acc_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (rd_rdy !== '0)    begin failures++; $display("FAIL reset_rd_rdy: got %b expected 0", rd_rdy); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        checks++; if (m_last !== 1'b0)  begin failures++; $display("FAIL reset_m_last: got %b expected 0", m_last); end
        checks++; if (m_data !== '0)    begin failures++; $display("FAIL reset_m_data: got %h expected 0", m_data); end
        checks++; if (m_block !== '0)   begin failures++; $display("FAIL reset_m_block: got %0d expected 0", m_block); end
        checks++; if (job_busy !== 1'b0) begin failures++; $display("FAIL reset_job_busy: got %b expected 0", job_busy); end
        checks++; if (job_done !== 1'b0) begin failures++; $display("FAIL reset_job_done: got %b expected 0", job_done); end
        rst = 1'b0;
        model_ptr = BC - 1;
    endtask

    task automatic test_single_group();
        bit to;
        int d;
        rdy_mode = 0;
        for (int i = 0; i < N; i++) fq[2].push_back(K'(32'hA0 + i));
        refresh();
        build_expected(1);
        start_job(1);
        checks++; if (job_busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b expected 1", job_busy); end
        wait_done(100, to);
        checks++; if (to) begin failures++; $display("FAIL single_timeout: job_done not seen in 100 cycles"); end
        checks++; if (first_valid_cyc - start_cyc !== 2) begin failures++; $display("FAIL single_latency: got %0d cycles expected 2", first_valid_cyc - start_cyc); end
        d = first_diff();
        checks++; if (d !== -1) begin failures++; $display("FAIL single_stream: got %0d words expected %0d, first difference at word %0d", acc_q.size(), exp_q.size(), d); end
        if (acc_q.size() == N) begin
            checks++; if (acc_cyc[N-1] - acc_cyc[0] !== N - 1) begin failures++; $display("FAIL single_bubbles: span %0d expected %0d", acc_cyc[N-1] - acc_cyc[0], N - 1); end
            checks++; if (done_cyc !== acc_cyc[N-1]) begin failures++; $display("FAIL single_done_timing: done at %0d expected %0d", done_cyc, acc_cyc[N-1]); end
        end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL single_done_pulses: got %0d expected 1", done_cnt); end
        checks++; if (job_busy !== 1'b0) begin failures++; $display("FAIL single_busy_clear: got %b expected 0", job_busy); end
    endtask

    task automatic test_round_robin();
        bit to;
        int d;
        int order_a[4] = '{0, 1, 2, 3};
        do_reset();
        rdy_mode = 0;
        for (int f = 0; f < BC; f++) fill_rand(f, N);
        refresh();
        build_expected(4);
        start_job(4);
        wait_done(200, to);
        checks++; if (to) begin failures++; $display("FAIL rr4_timeout: job_done not seen in 200 cycles"); end
        d = first_diff();
        checks++; if (d !== -1) begin failures++; $display("FAIL rr4_stream: got %0d words expected %0d, first difference at word %0d", acc_q.size(), exp_q.size(), d); end
        for (int g = 0; g < 4; g++) begin
            if (acc_q.size() > g * N) begin
                checks++;
                if (int'(acc_q[g*N].blk) !== order_a[g]) begin failures++; $display("FAIL rr4_order: group %0d from block %0d expected %0d", g, acc_q[g*N].blk, order_a[g]); end
            end
        end
        for (int f = 0; f < BC; f++) fill_rand(f, N);
        refresh();
        build_expected(2);
        start_job(2);
        wait_done(200, to);
        checks++; if (to) begin failures++; $display("FAIL rr2_timeout: job_done not seen in 200 cycles"); end
        d = first_diff();
        checks++; if (d !== -1) begin failures++; $display("FAIL rr2_stream: got %0d words expected %0d, first difference at word %0d", acc_q.size(), exp_q.size(), d); end
        for (int g = 0; g < 2; g++) begin
            if (acc_q.size() > g * N) begin
                checks++;
                if (int'(acc_q[g*N].blk) !== order_a[g]) begin failures++; $display("FAIL rr2_order: group %0d from block %0d expected %0d", g, acc_q[g*N].blk, order_a[g]); end
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int d;
        int avail;
        int g;
        for (int iter = 0; iter < 4; iter++) begin
            viol_stall = 0; viol_stable = 0; viol_onehot = 0; pop_cnt = 0;
            if (iter == 0) begin
                rdy_mode = 1;
                rdy_idx  = 0;
                fill_rand(0, N);
            end else begin
                rdy_mode = 2;
                for (int f = 0; f < BC; f++) fill_rand(f, $urandom_range(0, 7 - fq[f].size()));
            end
            avail = 0;
            for (int f = 0; f < BC; f++) if (fq[f].size() >= N) avail++;
            if (avail == 0) begin
                fill_rand(iter % BC, N - fq[iter % BC].size());
                avail = 1;
            end
            refresh();
            g = (iter == 0) ? 1 : $urandom_range(1, avail);
            build_expected(g);
            start_job(g);
            wait_done(300, to);
            checks++; if (to) begin failures++; $display("FAIL bp_timeout: iteration %0d job_done not seen", iter); end
            d = first_diff();
            checks++; if (d !== -1) begin failures++; $display("FAIL bp_stream: iteration %0d got %0d words expected %0d, first difference at word %0d", iter, acc_q.size(), exp_q.size(), d); end
            checks++; if (pop_cnt !== g * N) begin failures++; $display("FAIL bp_pops: iteration %0d got %0d pops expected %0d", iter, pop_cnt, g * N); end
            checks++; if (viol_stall !== 0) begin failures++; $display("FAIL bp_pop_while_stalled: got %0d events expected 0", viol_stall); end
            checks++; if (viol_stable !== 0) begin failures++; $display("FAIL bp_stable: got %0d changes during stall expected 0", viol_stable); end
            checks++; if (viol_onehot !== 0) begin failures++; $display("FAIL bp_onehot: got %0d multi-pop cycles expected 0", viol_onehot); end
        end
        rdy_mode = 0;
    endtask

    task automatic test_partial_fill();
        bit to;
        int d;
        do_reset();
        for (int f = 0; f < BC; f++) fq[f].delete();
        fill_rand(1, N - 1);
        fill_rand(3, N);
        refresh();
        build_expected(1);
        start_job(1);
        wait_done(100, to);
        checks++; if (to) begin failures++; $display("FAIL partial_timeout: job_done not seen"); end
        d = first_diff();
        checks++; if (d !== -1) begin failures++; $display("FAIL partial_stream: got %0d words expected %0d, first difference at word %0d", acc_q.size(), exp_q.size(), d); end
        checks++; if (acc_q.size() == 0 || acc_q[0].blk !== IW'(3)) begin failures++; $display("FAIL partial_first_block: got %0d expected 3", (acc_q.size() > 0) ? int'(acc_q[0].blk) : -1); end
        pop_cnt = 0;
        start_job(1);
        repeat (10) step();
        job_groups = 32'd5;
        job_start  = 1'b1;
        step();
        job_start  = 1'b0;
        repeat (5) step();
        checks++; if (pop_cnt !== 0) begin failures++; $display("FAIL partial_no_pop: got %0d pops expected 0", pop_cnt); end
        checks++; if (job_busy !== 1'b1 || m_valid !== 1'b0) begin failures++; $display("FAIL partial_waiting: busy=%b valid=%b expected busy=1 valid=0", job_busy, m_valid); end
        fill_rand(1, 1);
        refresh();
        build_expected(1);
        wait_done(100, to);
        checks++; if (to) begin failures++; $display("FAIL partial_late_timeout: job_done not seen after Nth word"); end
        d = first_diff();
        checks++; if (d !== -1) begin failures++; $display("FAIL partial_late_stream: got %0d words expected %0d, first difference at word %0d", acc_q.size(), exp_q.size(), d); end
        checks++; if (done_cnt !== 1 || job_busy !== 1'b0) begin failures++; $display("FAIL partial_ignored_start: done pulses %0d busy %b expected 1 and 0", done_cnt, job_busy); end
        pop_cnt = 0;
        start_job(0);
        wait_done(20, to);
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL zero_job_done: got %0d pulses expected 1", done_cnt); end
        checks++; if (pop_cnt !== 0) begin failures++; $display("FAIL zero_job_pops: got %0d pops expected 0", pop_cnt); end
        checks++; if (job_busy !== 1'b0) begin failures++; $display("FAIL zero_job_busy: got %b expected 0", job_busy); end
    endtask

    task automatic test_reset_midgroup();
        bit to;
        int d;
        int n;
        rdy_mode = 0;
        for (int f = 0; f < BC; f++) fq[f].delete();
        fill_rand(0, N);
        refresh();
        start_job(1);
        n = 0;
        while (acc_q.size() < 2 && n < 20) begin
            step();
            n++;
        end
        checks++; if (acc_q.size() < 2 || m_valid !== 1'b1) begin failures++; $display("FAIL midrst_setup: got %0d words valid=%b expected 2 words valid=1", acc_q.size(), m_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin failures++; $display("FAIL midrst_valid: valid=%b last=%b expected 0 0", m_valid, m_last); end
        checks++; if (m_data !== '0 || m_block !== '0) begin failures++; $display("FAIL midrst_data: data=%h block=%0d expected 0 0", m_data, m_block); end
        checks++; if (rd_rdy !== '0 || job_busy !== 1'b0 || job_done !== 1'b0) begin failures++; $display("FAIL midrst_ctrl: rd_rdy=%b busy=%b done=%b expected 0 0 0", rd_rdy, job_busy, job_done); end
        @(negedge clk);
        rst = 1'b0;
        model_ptr  = BC - 1;
        prev_stall = 1'b0;
        for (int f = 0; f < BC; f++) fq[f].delete();
        fill_rand(2, N);
        refresh();
        build_expected(1);
        start_job(1);
        checks++; if (job_busy !== 1'b1) begin failures++; $display("FAIL midrst_restart_busy: got %b expected 1", job_busy); end
        wait_done(100, to);
        checks++; if (to) begin failures++; $display("FAIL midrst_restart_timeout: job_done not seen"); end
        d = first_diff();
        checks++; if (d !== -1) begin failures++; $display("FAIL midrst_restart_stream: got %0d words expected %0d, first difference at word %0d", acc_q.size(), exp_q.size(), d); end
    endtask

    initial begin
        rst        = 1'b1;
        job_start  = 1'b0;
        job_groups = '0;
        m_ready    = 1'b0;
        rd_dout    = '0;
        rd_cnt     = '0;
        test_reset();
        test_single_group();
        test_round_robin();
        test_backpressure();
        test_partial_fill();
        test_reset_midgroup();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
